ysyx_22040632_booth_mul_seq: RTL and testbench

YSYX_22040632_BOOTH_MUL_SEQ -- requirements
Module: ysyx_22040632_booth_mul_seq

---
 rtl/ysyx_22040632_booth_mul_seq.sv | 124 ++++++++++++
 tb/tb_ysyx_22040632_booth_mul_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040632_booth_mul_seq.sv
// Sequential radix-4 Booth multiplier; optional abort port under YSYX_22040632_MUL_FLUSH_EN.
// One digit per CALC cycle (XLEN/2+1 cycles); result held in DONE until out_ready.
module ysyx_22040632_booth_mul_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] in_x,
  input  logic [XLEN-1:0] in_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo,
  output logic            busy
`ifdef YSYX_22040632_MUL_FLUSH_EN
  ,
  input  logic            flush
`endif
);

  localparam int EW = XLEN + 2;
  localparam int AW = 2 * XLEN + 2;
  localparam int N  = XLEN / 2 + 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   mcand_q, mcand_d;
  logic [EW:0]     mplier_q, mplier_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [AW-1:0]   x_ext;
  logic [EW-1:0]   y_ext;
  logic [AW-1:0]   pp;
  logic [AW-1:0]   pp_term;
  logic            neg;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result_hi = acc_q[2*XLEN-1:XLEN];
  assign result_lo = acc_q[XLEN-1:0];

  always_comb begin
    x_ext = {{(AW-XLEN){mul_signed[1] & in_x[XLEN-1]}}, in_x};
    y_ext = {{2{mul_signed[0] & in_y[XLEN-1]}}, in_y};
  end

  // Booth digit from {y[2i+1], y[2i], y[2i-1]}; mplier_q carries the implicit 0 at bit 0.
  always_comb begin
    pp  = '0;
    neg = 1'b0;
    case (mplier_q[2:0])
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = {mcand_q[AW-2:0], 1'b0};
      3'b100: begin
        pp  = {mcand_q[AW-2:0], 1'b0};
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        pp  = mcand_q;
        neg = 1'b1;
      end
      default: pp = '0;
    endcase
    pp_term = neg ? ~pp : pp;
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = x_ext;
          mplier_d = {y_ext, 1'b0};
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ((in_x == '0) || (in_y == '0)) ? DONE : CALC;
        end
      end
      CALC: begin
        acc_d    = acc_q + pp_term + AW'(neg);
        mcand_d  = {mcand_q[AW-3:0], 2'b00};
        mplier_d = mplier_q >> 2;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef YSYX_22040632_MUL_FLUSH_EN
    // Abort wins over a pending handshake on the result side.
    if (flush && (state_q != IDLE)) state_d = IDLE;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040632_booth_mul_seq.sv
// Bench for the sequential Booth multiplier: directed corner cases plus random operands vs a plain-multiply model.
module tb_ysyx_22040632_booth_mul_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   mul_signed;
  logic [63:0]  in_x;
  logic [63:0]  in_y;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  result_hi;
  logic [63:0]  result_lo;
  logic         busy;
`ifdef YSYX_22040632_MUL_FLUSH_EN
  logic         flush;
`endif

  int n_tests;
  int n_fail;

  ysyx_22040632_booth_mul_seq #(.XLEN(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mul_signed (mul_signed),
    .in_x       (in_x),
    .in_y       (in_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_hi  (result_hi),
    .result_lo  (result_lo),
    .busy       (busy)
`ifdef YSYX_22040632_MUL_FLUSH_EN
    ,
    .flush      (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model(input logic [63:0] x, input logic [63:0] y,
                                         input logic [1:0] s);
    logic [127:0] xe;
    logic [127:0] ye;
    xe = s[1] ? {{64{x[63]}}, x} : {64'b0, x};
    ye = s[0] ? {{64{y[63]}}, y} : {64'b0, y};
    return xe * ye;
  endfunction

  // Presents an operation now (caller is at a negedge with the DUT idle), returns
  // at the first negedge with out_valid high; lat counts edges from the accept edge.
  task automatic run_op(input logic [63:0] x, input logic [63:0] y, input logic [1:0] s,
                        output logic [127:0] res, output int lat);
    in_valid   = 1'b1;
    in_x       = x;
    in_y       = y;
    mul_signed = s;
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 100) begin
      in_valid   = 1'($urandom);
      in_x       = {$urandom, $urandom};
      in_y       = {$urandom, $urandom};
      mul_signed = 2'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    res = {result_hi, result_lo};
  endtask

  logic [127:0] res;
  logic [127:0] held;
  int           lat;
  logic [63:0]  rx, ry;
  logic [1:0]   rs;
  int           seen_valid;

  function automatic logic [63:0] pick(input int sel);
    logic [63:0] v;
    case (sel)
      0:       v = 64'h0;
      1:       v = 64'h8000_0000_0000_0000;
      2:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      3:       v = 64'h7FFF_FFFF_FFFF_FFFF;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_x       = '0;
    in_y       = '0;
    mul_signed = 2'b00;
    out_ready  = 1'b1;
`ifdef YSYX_22040632_MUL_FLUSH_EN
    flush      = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", {result_hi, result_lo}, 0);

    // Release and present on the same negedge: accept must happen on the first edge.
    rst_n = 1'b1;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, res, lat);
    chk("uns_max_res", res, {64'hFFFF_FFFF_FFFF_FFFE, 64'h1});
    chk("uns_max_lat", lat, 34);
    chk("done_in_ready", in_ready, 0);
    @(negedge clk);

    run_op(-64'sd3, 64'd7, 2'b11, res, lat);
    chk("m3x7", res, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB});
    @(negedge clk);

    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b11, res, lat);
    chk("minxmin", res, {64'h4000_0000_0000_0000, 64'h0});
    @(negedge clk);

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b10, res, lat);
    chk("mixed_m1x2", res, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE});
    @(negedge clk);

    run_op(64'h0, 64'h1234, 2'b00, res, lat);
    chk("zero_res", res, 0);
    chk("zero_lat", lat, 1);
    @(negedge clk);

    // Result held under backpressure; handoff cycle refuses a new request.
    out_ready = 1'b0;
    run_op(64'd123456789, 64'd987654321, 2'b00, res, lat);
    held = res;
    chk("stall_res", res, model(64'd123456789, 64'd987654321, 2'b00));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold", {result_hi, result_lo}, held);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_x       = 64'd5;
    in_y       = 64'd5;
    @(negedge clk);
    chk("handoff_idle", in_ready, 1);
    chk("handoff_no_accept", busy, 0);
    chk("handoff_valid_low", out_valid, 0);
    in_valid = 1'b0;

    // Reset during CALC discards the operation.
    in_valid = 1'b1;
    in_x     = 64'd77;
    in_y     = 64'd99;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("calc_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_result", {result_hi, result_lo}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    chk("arst_no_valid", seen_valid, 0);

`ifdef YSYX_22040632_MUL_FLUSH_EN
    in_valid = 1'b1;
    in_x     = 64'd31;
    in_y     = 64'd17;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle", in_ready, 1);
    chk("flush_valid", out_valid, 0);
    seen_valid = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    chk("flush_no_valid", seen_valid, 0);
`endif

    for (int k = 0; k < 24; k++) begin
      rx = pick($urandom_range(0, 9));
      ry = pick($urandom_range(0, 9));
      rs = 2'($urandom);
      run_op(rx, ry, rs, res, lat);
      chk("rand_res", res, model(rx, ry, rs));
      chk("rand_lat", lat, ((rx == 0) || (ry == 0)) ? 1 : 34);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
